// File: rtl/cpu7_mem_arbiter_if.sv
// rtl/cpu7_mem_arbiter_if.sv - core request/ack bundle plus shared RAM port for cpu7_mem_arbiter
interface cpu7_mem_arbiter_if #(
  parameter int CORES      = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  localparam int OWNER_WIDTH = (CORES > 1) ? $clog2(CORES) : 1;

  logic [CORES-1:0]            req;
  logic [CORES-1:0]            we;
  logic [CORES*ADDR_WIDTH-1:0] addr;
  logic [CORES*DATA_WIDTH-1:0] wdata;
  logic [CORES-1:0]            ack;
  logic [DATA_WIDTH-1:0]       rdata;
  logic                        busy;
  logic [OWNER_WIDTH-1:0]      owner;
  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]       mem_wdata;
  logic [DATA_WIDTH-1:0]       mem_rdata;

  // cores and RAM side
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata
  );

  // arbiter side
  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpu7_mem_arbiter.sv
// rtl/cpu7_mem_arbiter.sv - round-robin arbiter serialising core accesses to one single-port RAM
module cpu7_mem_arbiter #(
  parameter int CORES      = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  cpu7_mem_arbiter_if.slave bus
);
  localparam int OW = (CORES > 1) ? $clog2(CORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic [OW-1:0]         last, last_nxt;
  logic [OW-1:0]         owner_q, owner_nxt;
  logic [CORES-1:0]      ack_q, ack_nxt;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_nxt;
  logic                  busy_q, busy_nxt;
  logic                  mem_en_q, mem_en_nxt;
  logic                  mem_we_q, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_nxt;

  logic [CORES-1:0]      eligible;
  logic                  grant_found;
  logic [OW-1:0]         grant_idx;
  int                    idx;

  // Round-robin pick: first eligible core after the last owner; the acked core is masked
  always_comb begin
    eligible    = bus.req & ~ack_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= CORES; k++) begin
      idx = (int'(last) + k) % CORES;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = OW'(idx);
      end
    end
  end

  // Next-state and next-output logic; every output comes straight from a register
  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    owner_nxt     = owner_q;
    ack_nxt       = '0;
    rdata_nxt     = rdata_q;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt     = ACCESS;
          owner_nxt     = grant_idx;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = bus.we[grant_idx];
          mem_addr_nxt  = bus.addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_nxt = bus.wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        state_nxt        = IDLE;
        rdata_nxt        = bus.mem_rdata;
        ack_nxt[owner_q] = 1'b1;
        last_nxt         = owner_q;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= OW'(CORES - 1);
      owner_q     <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      owner_q     <= owner_nxt;
      ack_q       <= ack_nxt;
      rdata_q     <= rdata_nxt;
      busy_q      <= busy_nxt;
      mem_en_q    <= mem_en_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_cpu7_mem_arbiter.sv
// tb/tb_cpu7_mem_arbiter.sv - directed and randomized self-checking bench for cpu7_mem_arbiter
module tb_cpu7_mem_arbiter;
  localparam int CORES = 4;
  localparam int AW    = 10;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  cpu7_mem_arbiter_if #(.CORES(CORES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cpu7_mem_arbiter #(.CORES(CORES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // core-side drivers
  logic [CORES-1:0] req_v;
  logic [CORES-1:0] we_v;
  logic [AW-1:0]    a_v [CORES];
  logic [DW-1:0]    d_v [CORES];

  assign bus.req = req_v;
  assign bus.we  = we_v;
  for (genvar gi = 0; gi < CORES; gi++) begin : g_pack
    assign bus.addr[gi*AW +: AW]  = a_v[gi];
    assign bus.wdata[gi*DW +: DW] = d_v[gi];
  end

  // single-port synchronous RAM, one-cycle read latency, with a bench preload port
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_v = '0;
    we_v  = '0;
    tick();
    rst   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, bus.ack, 0);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_owner"}, bus.owner, 0);
    check({tag, "_mem_en"}, bus.mem_en, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  int               cnt, mlast, g, idx, en_cnt, a1_cnt, req3_start;
  int               order_q[$];
  logic [CORES-1:0] req_before, elig, prev_ack, hold_drop, reraise;
  logic             g_we;
  logic [AW-1:0]    g_addr;
  logic [DW-1:0]    g_data;
  logic [DW-1:0]    shadow [0:15];

  initial begin
    rst       = 1'b1;
    poke_en   = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    req_v     = '0;
    we_v      = '0;
    for (int i = 0; i < CORES; i++) begin
      a_v[i] = '0;
      d_v[i] = '0;
    end
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    poke(10'h005, 8'hA5);
    poke(10'h010, 8'h00);

    // 1: core2 reads 0x005
    a_v[2] = 10'h005;
    req_v  = 4'b0100;
    tick();
    check("t1_mem_en", bus.mem_en, 1);
    check("t1_mem_we", bus.mem_we, 0);
    check("t1_mem_addr", bus.mem_addr, 32'h005);
    check("t1_busy_n1", bus.busy, 1);
    check("t1_owner", bus.owner, 2);
    tick();
    check("t1_busy_n2", bus.busy, 1);
    check("t1_mem_en_n2", bus.mem_en, 0);
    check("t1_ack_n2", bus.ack, 0);
    tick();
    check("t1_ack", bus.ack, 32'b0100);
    check("t1_rdata", bus.rdata, 32'hA5);
    check("t1_busy_n3", bus.busy, 0);
    tick();
    req_v = '0;
    check("t1_no_regrant", bus.mem_en, 0);
    check("t1_ack_n4", bus.ack, 0);
    check("t1_rdata_hold", bus.rdata, 32'hA5);

    // 2: core1 writes 0x3C to 0x010, then reads it back
    a_v[1]  = 10'h010;
    d_v[1]  = 8'h3C;
    we_v[1] = 1'b1;
    req_v   = 4'b0010;
    tick();
    check("t2_mem_en", bus.mem_en, 1);
    check("t2_mem_we", bus.mem_we, 1);
    check("t2_mem_addr", bus.mem_addr, 32'h010);
    check("t2_mem_wdata", bus.mem_wdata, 32'h3C);
    tick();
    tick();
    check("t2_wack", bus.ack, 32'b0010);
    req_v   = '0;
    we_v[1] = 1'b0;
    tick();
    req_v = 4'b0010;
    tick();
    check("t2_rd_mem_we", bus.mem_we, 0);
    check("t2_rd_mem_en", bus.mem_en, 1);
    tick();
    tick();
    check("t2_rack", bus.ack, 32'b0010);
    check("t2_rdata", bus.rdata, 32'h3C);
    req_v = '0;
    tick();

    // 3: all cores request together after reset
    do_reset();
    req_v = 4'b1111;
    for (int k = 0; k < CORES; k++) begin
      tick();
      check("t3_owner", bus.owner, k);
      check("t3_mem_en", bus.mem_en, 1);
      tick();
      tick();
      check("t3_ack", bus.ack, 32'(1 << k));
      req_v[k] = 1'b0;
    end
    tick();

    // 4: cores 0 and 3 re-request right after each ack
    do_reset();
    req_v      = 4'b1001;
    req3_start = 0;
    reraise    = '0;
    order_q.delete();
    for (int c = 1; c <= 30; c++) begin
      tick();
      for (int i = 0; i < CORES; i++) begin
        if (reraise[i]) begin
          req_v[i]   = 1'b1;
          reraise[i] = 1'b0;
          if (i == 3) req3_start = c;
        end
      end
      check("t4_onehot", 32'($countones(bus.ack) <= 1), 1);
      for (int i = 0; i < CORES; i++) begin
        if (bus.ack[i]) begin
          order_q.push_back(i);
          req_v[i]   = 1'b0;
          reraise[i] = 1'b1;
          if (i == 3) check("t4_wait3", 32'((c - req3_start) <= 6), 1);
        end
      end
    end
    req_v = '0;
    check("t4_ack_count", order_q.size(), 10);
    foreach (order_q[i]) check("t4_order", order_q[i], (i % 2 == 0) ? 0 : 3);
    tick();

    // 5: core1 pulses req while core0 is mid-access
    do_reset();
    a_v[0] = 10'h005;
    req_v  = 4'b0001;
    tick();
    check("t5_mem_en", bus.mem_en, 1);
    en_cnt   = 1;
    a1_cnt   = 0;
    req_v[1] = 1'b1;
    tick();
    req_v[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.mem_en) en_cnt++;
      if (bus.ack[1]) a1_cnt++;
      if (bus.ack[0]) req_v[0] = 1'b0;
    end
    check("t5_en_pulses", en_cnt, 1);
    check("t5_ack1", a1_cnt, 0);

    // 6: reset during core2 ACCESS
    do_reset();
    a_v[2] = 10'h005;
    a_v[0] = 10'h007;
    req_v  = 4'b0100;
    tick();
    check("t6_access", bus.mem_en, 1);
    rst   = 1'b1;
    req_v = '0;
    tick();
    check_reset_values("t6");
    rst = 1'b0;
    tick();
    check("t6_no_ack_a", bus.ack, 0);
    tick();
    check("t6_no_ack_b", bus.ack, 0);
    req_v = 4'b0101;
    tick();
    check("t6_first_owner", bus.owner, 0);
    check("t6_first_addr", bus.mem_addr, 32'h007);
    tick();
    tick();
    check("t6_ack0", bus.ack, 32'b0001);
    req_v[0] = 1'b0;
    tick();
    check("t6_second_owner", bus.owner, 2);
    tick();
    tick();
    check("t6_ack2", bus.ack, 32'b0100);
    req_v = '0;
    tick();

    // random traffic against a transaction-level reference model
    do_reset();
    for (int a = 0; a < 16; a++) begin
      shadow[a] = DW'($urandom);
      poke(AW'(a), shadow[a]);
    end
    cnt       = 0;
    mlast     = CORES - 1;
    g         = 0;
    prev_ack  = '0;
    hold_drop = '0;
    g_we      = 1'b0;
    g_addr    = '0;
    g_data    = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_before = req_v;
      tick();
      if (cnt == 2) begin
        check("r_access_en", bus.mem_en, 0);
        check("r_access_ack", bus.ack, 0);
        check("r_access_busy", bus.busy, 1);
        cnt = 1;
      end else if (cnt == 1) begin
        check("r_ack", bus.ack, 32'(1 << g));
        check("r_ack_busy", bus.busy, 0);
        check("r_ack_en", bus.mem_en, 0);
        if (!g_we) check("r_rdata", bus.rdata, shadow[g_addr[3:0]]);
        else shadow[g_addr[3:0]] = g_data;
        mlast = g;
        cnt   = 0;
      end else begin
        elig = req_before & ~prev_ack;
        if (elig != '0) begin
          g = -1;
          for (int k = 1; k <= CORES; k++) begin
            idx = (mlast + k) % CORES;
            if (g < 0 && elig[idx]) g = idx;
          end
          g_we   = we_v[g];
          g_addr = a_v[g];
          g_data = d_v[g];
          check("r_owner", bus.owner, g);
          check("r_grant_en", bus.mem_en, 1);
          check("r_grant_we", bus.mem_we, g_we);
          check("r_grant_addr", bus.mem_addr, g_addr);
          if (g_we) check("r_grant_wdata", bus.mem_wdata, g_data);
          check("r_grant_busy", bus.busy, 1);
          check("r_grant_ack", bus.ack, 0);
          cnt = 2;
        end else begin
          check("r_idle_en", bus.mem_en, 0);
          check("r_idle_busy", bus.busy, 0);
          check("r_idle_ack", bus.ack, 0);
        end
      end
      prev_ack = bus.ack;
      for (int i = 0; i < CORES; i++) begin
        if (bus.ack[i]) begin
          if ($urandom_range(1) == 0) req_v[i] = 1'b0;
          else hold_drop[i] = 1'b1;
        end else if (hold_drop[i]) begin
          req_v[i]     = 1'b0;
          hold_drop[i] = 1'b0;
        end else if (!req_v[i]) begin
          if ($urandom_range(2) == 0) begin
            req_v[i] = 1'b1;
            we_v[i]  = 1'($urandom_range(1));
            a_v[i]   = AW'($urandom_range(15));
            d_v[i]   = DW'($urandom);
          end
        end else if (!(cnt != 0 && g == i) && $urandom_range(15) == 0) begin
          req_v[i] = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
